blink_rate_decoder: RTL and testbench

Receive-side counterpart of the team's multi-rate LED toggle generator. It samples one asynchronous square-wave input, measures the clock cycles between successive edges (half-period), and classifies the result into one of four toggle rates. A class is reported only after repeated agreement. Used for loop-back self-test of the LED driver outputs and for decoding blink-coded status from another board.

---
 rtl/blink_pkg.sv | 23 ++
 rtl/sig_edge_det.sv | 71 +++++++
 rtl/blink_rate_decoder.sv | 177 +++++++++++++++++
 tb/tb_blink_rate_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the blink-rate decoder: rate codes, FSM states and
// the nominal half-period helper.
package blink_pkg;

  localparam logic [2:0] RATE_NONE = 3'd0;
  localparam logic [2:0] RATE_1    = 3'd1;
  localparam logic [2:0] RATE_2    = 3'd2;
  localparam logic [2:0] RATE_3    = 3'd3;
  localparam logic [2:0] RATE_4    = 3'd4;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Rounded clk_hz / (k+1): the nominal half-period of toggle rate k.
  function automatic logic [63:0] hp_nom(input logic [63:0] clk_hz, input int unsigned k);
    logic [63:0] div;
    div = 64'(k) + 64'd1;
    return (clk_hz + (div >> 1)) / div;
  endfunction

endpackage

// File: rtl/sig_edge_det.sv
// Synchronises the raw square wave and emits a one-cycle pulse on every level
// change. Optional stability filter enabled by defining GLITCH_FILTER_EN.
module sig_edge_det
`ifdef GLITCH_FILTER_EN
#(
  parameter int unsigned GLITCH_CYC = 16
)
`endif
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_edge;
  logic w_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GLITCH_CYC - 1);

  logic          r_filt;
  logic [GW-1:0] r_gcnt;

  // A new level is accepted only after GLITCH_CYC consecutive cycles of disagreement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt <= 1'b0;
      r_gcnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_gcnt <= '0;
    end else if (r_gcnt == G_LAST) begin
      r_filt <= r_sync2;
      r_gcnt <= '0;
    end else begin
      r_gcnt <= r_gcnt + GW'(1);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_edge <= w_level ^ r_prev;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/blink_rate_decoder.sv
// Measures the half-period of an incoming square wave and locks onto one of
// four toggle rates. GLITCH_FILTER_EN adds an input stability filter.
module blink_rate_decoder
  import blink_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
`ifdef GLITCH_FILTER_EN
  parameter int unsigned GLITCH_CYC  = 16,
`endif
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TOL_SHIFT   = 4,
  parameter int unsigned LOCK_CNT    = 2,
  parameter int unsigned TIMEOUT_CYC = 2 * CLK_HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [2:0]       rate_code,
  output logic             locked,
  output logic             rate_valid,
  output logic [CNT_W-1:0] half_period,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HP0     = CNT_W'(hp_nom(64'(CLK_HZ), 0));
  localparam logic [CNT_W-1:0] HP1     = CNT_W'(hp_nom(64'(CLK_HZ), 1));
  localparam logic [CNT_W-1:0] HP2     = CNT_W'(hp_nom(64'(CLK_HZ), 2));
  localparam logic [CNT_W-1:0] HP3     = CNT_W'(hp_nom(64'(CLK_HZ), 3));
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TMO) ? TMO : v + CNT_ONE;
  endfunction

  function automatic logic [3:0] lock_inc(input logic [3:0] v);
    return (v >= LOCK_MAX) ? LOCK_MAX : v + 4'd1;
  endfunction

  // Larger minus smaller keeps the distance unsigned without wrap.
  function automatic logic in_win(input logic [CNT_W-1:0] m, input logic [CNT_W-1:0] hp);
    logic [CNT_W-1:0] diff;
    diff = (m >= hp) ? (m - hp) : (hp - m);
    return diff <= (hp >> TOL_SHIFT);
  endfunction

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] m);
    if (in_win(m, HP0)) return RATE_1;
    if (in_win(m, HP1)) return RATE_2;
    if (in_win(m, HP2)) return RATE_3;
    if (in_win(m, HP3)) return RATE_4;
    return RATE_NONE;
  endfunction

  logic             r_rst_meta;
  logic             r_rst_sync;
  logic             w_edge;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       r_lock;
  logic [3:0]       w_lock_next;
  logic [2:0]       r_prev_cls;
  logic [2:0]       w_cls;
  logic             w_meas_fire;
  logic             w_expire;
  logic             w_lock_hit;
  logic             r_rate_valid;
  logic             r_timeout;
  logic             r_locked;
  logic [2:0]       r_rate_code;
  logic [CNT_W-1:0] r_half;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  sig_edge_det
`ifdef GLITCH_FILTER_EN
  #(
    .GLITCH_CYC (GLITCH_CYC)
  )
`endif
  u_edge (
    .i_clk   (clk),
    .i_rst_n (r_rst_sync),
    .i_sig   (sig_in),
    .o_edge  (w_edge)
  );

  assign w_cnt_inc = sat_inc(r_cnt);
  // An edge in the expiry cycle is a measurement, never a timeout.
  assign w_expire  = (r_state == MEASURE) && !w_edge && (w_cnt_inc == TMO);

  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) r_state <= IDLE;
    else             r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_edge)   w_state_next = MEASURE;
      MEASURE: if (w_expire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_meas_fire = (r_state == MEASURE) && w_edge;
    w_cls       = classify(r_cnt);
    w_cnt_next  = r_cnt;
    w_lock_next = r_lock;
    case (r_state)
      IDLE:    w_cnt_next = w_edge ? CNT_ONE : '0;
      MEASURE: begin
        if (w_edge)        w_cnt_next = CNT_ONE;
        else if (w_expire) w_cnt_next = '0;
        else               w_cnt_next = w_cnt_inc;
      end
      default: w_cnt_next = '0;
    endcase
    if (w_meas_fire) begin
      if (w_cls == RATE_NONE)       w_lock_next = 4'd0;
      else if (w_cls == r_prev_cls) w_lock_next = lock_inc(r_lock);
      else                          w_lock_next = 4'd1;
    end else if (w_expire) begin
      w_lock_next = 4'd0;
    end
    w_lock_hit = (w_lock_next == LOCK_MAX) && (w_cls != RATE_NONE);
  end

  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_cnt        <= '0;
      r_lock       <= 4'd0;
      r_prev_cls   <= RATE_NONE;
      r_rate_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_locked     <= 1'b0;
      r_rate_code  <= RATE_NONE;
      r_half       <= '0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_lock       <= w_lock_next;
      r_rate_valid <= w_meas_fire;
      r_timeout    <= w_expire;
      if (w_meas_fire) begin
        r_half      <= r_cnt;
        r_prev_cls  <= w_cls;
        r_locked    <= w_lock_hit;
        r_rate_code <= w_lock_hit ? w_cls : RATE_NONE;
      end else if (w_expire) begin
        r_prev_cls  <= RATE_NONE;
        r_locked    <= 1'b0;
        r_rate_code <= RATE_NONE;
      end
    end
  end

  assign rate_code   = r_rate_code;
  assign locked      = r_locked;
  assign rate_valid  = r_rate_valid;
  assign half_period = r_half;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed bench for blink_rate_decoder with a measurement scoreboard
// (CLK_HZ=1200, TIMEOUT_CYC=2400, LOCK_CNT=2).
module tb_blink_rate_decoder;

`ifdef GLITCH_FILTER_EN
  localparam int G = 16;
`else
  localparam int G = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic [2:0]  rate_code;
  logic        locked;
  logic        rate_valid;
  logic [31:0] half_period;
  logic        timeout;

  blink_rate_decoder #(
    .CLK_HZ      (1200),
    .CNT_W       (32),
    .TOL_SHIFT   (4),
    .LOCK_CNT    (2),
    .TIMEOUT_CYC (2400)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .rate_code   (rate_code),
    .locked      (locked),
    .rate_valid  (rate_valid),
    .half_period (half_period),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int half;
    bit lk;
    int code;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rv_count = 0;
  int   tmo_count = 0;
  int   tmo_cyc  = -1;

  bit m_active = 0;
  int m_last   = 0;
  int m_prev   = 0;
  int m_lock   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int cls_of(input int m);
    int hp[4]  = '{1200, 600, 400, 300};
    int tol[4] = '{75, 37, 25, 18};
    for (int k = 0; k < 4; k++) begin
      if (((m > hp[k]) ? (m - hp[k]) : (hp[k] - m)) <= tol[k]) return k + 1;
    end
    return 0;
  endfunction

  task automatic model_edge();
    int   meas;
    int   c;
    exp_t e;
    if (m_active) begin
      meas = cyc - m_last;
      c    = cls_of(meas);
      if (c == 0)           m_lock = 0;
      else if (c == m_prev) m_lock = (m_lock < 2) ? m_lock + 1 : 2;
      else                  m_lock = 1;
      m_prev = c;
      e.half = meas;
      e.lk   = (m_lock == 2) && (c != 0);
      e.code = e.lk ? c : 0;
      e.cyc  = cyc + 4 + G;
      sb.push_back(e);
    end
    m_active = 1;
    m_last   = cyc;
  endtask

  task automatic model_clear();
    m_active = 0;
    m_prev   = 0;
    m_lock   = 0;
  endtask

  task automatic toggle_after(input int n);
    repeat (n) @(posedge clk);
    #1;
    sig_in = ~sig_in;
    model_edge();
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (rate_valid) begin
        rv_count++;
        chk("rv_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("half_period", 64'(half_period), 64'(e.half));
          chk("locked", 64'(locked), 64'(e.lk));
          chk("rate_code", 64'(rate_code), 64'(e.code));
          chk("rv_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (timeout) begin
        tmo_count++;
        tmo_cyc = cyc;
        chk("tmo_locked", 64'(locked), 64'd0);
        chk("tmo_code", 64'(rate_code), 64'd0);
      end
    end
  end

  initial begin
    int c_last;
    int n_rv;
    rst    = 1'b0;
    sig_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_code", 64'(rate_code), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_rv", 64'(rate_valid), 64'd0);
    chk("rst_half", 64'(half_period), 64'd0);
    chk("rst_tmo", 64'(timeout), 64'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    toggle_after(5);
    repeat (4) toggle_after(600);
    repeat (4) toggle_after(300);
    repeat (3) toggle_after(1200);
    repeat (4) toggle_after(500);
    repeat (10) @(posedge clk);
    #1;
    chk("r500_locked", 64'(locked), 64'd0);
    chk("r500_code", 64'(rate_code), 64'd0);
    chk("r500_half", 64'(half_period), 64'd500);

    toggle_after(637);
    toggle_after(637);
    toggle_after(638);
    toggle_after(1125);
    toggle_after(1275);
    toggle_after(2399);
    repeat (3) toggle_after(400);
    c_last = cyc;
    chk("no_tmo_yet", 64'(tmo_count), 64'd0);

    repeat (2450) @(posedge clk);
    #1;
    chk("tmo_count", 64'(tmo_count), 64'd1);
    chk("tmo_time", 64'(tmo_cyc), 64'(c_last + 3 + G + 2400));
    chk("post_tmo_locked", 64'(locked), 64'd0);
    chk("post_tmo_code", 64'(rate_code), 64'd0);
    chk("post_tmo_half", 64'(half_period), 64'd400);
    model_clear();

    n_rv = rv_count;
    toggle_after(5);
    toggle_after(600);
    toggle_after(600);
    repeat (200) @(posedge clk);
    #1;
    chk("idle_edge_no_rv", 64'(rv_count), 64'(n_rv + 2));
    chk("pre_rst_locked", 64'(locked), 64'd1);
    chk("pre_rst_sb_empty", 64'(sb.size()), 64'd0);

    rst    = 1'b0;
    sig_in = 1'b0;
    #1;
    chk("mid_rst_code", 64'(rate_code), 64'd0);
    chk("mid_rst_locked", 64'(locked), 64'd0);
    chk("mid_rst_rv", 64'(rate_valid), 64'd0);
    chk("mid_rst_half", 64'(half_period), 64'd0);
    chk("mid_rst_tmo", 64'(timeout), 64'd0);
    model_clear();
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    toggle_after(5);
    toggle_after(300);
    toggle_after(300);

`ifdef GLITCH_FILTER_EN
    toggle_after(600);
    toggle_after(600);
    n_rv = rv_count;
    repeat (300) @(posedge clk);
    #1;
    sig_in = ~sig_in;
    repeat (5) @(posedge clk);
    #1;
    sig_in = ~sig_in;
    repeat (200) @(posedge clk);
    #1;
    chk("spike_no_rv", 64'(rv_count), 64'(n_rv));
    chk("spike_locked", 64'(locked), 64'd1);
    chk("spike_code", 64'(rate_code), 64'd2);
    chk("spike_half", 64'(half_period), 64'd600);
    toggle_after(95);
`endif

    repeat (40) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("tmo_total", 64'(tmo_count), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
